// File: rtl/tt_um_onehot_pulse_decoder_if.sv
// tt_um_onehot_pulse_decoder_if: Tiny Tapeout pin bundle (ui/uo/uio/ena) for the one-hot pulse decoder
interface tt_um_onehot_pulse_decoder_if;
  logic [7:0] ui_in, uo_out, uio_in, uio_out, uio_oe;
  logic ena;
  modport master (output ui_in, uio_in, ena, input uo_out, uio_out, uio_oe);
  modport slave (input ui_in, uio_in, ena, output uo_out, uio_out, uio_oe);
endinterface

// File: rtl/tt_um_onehot_pulse_decoder.sv
// tt_um_onehot_pulse_decoder: 3-bit code to one-hot decoder, output held or emitted as a timed pulse
// clk/rst_n: rising-edge clock, asynchronous active-low reset
// bus.ui_in: [2:0] code, [3] valid, [4] load, [5] mode (0 hold, 1 pulse), [7:6] len_sel
// bus.uo_out: one-hot decoded code or 0; bus.uio_out: {2'b0, overrun, done, busy, code_reg}
// bus.uio_oe: constant 8'h3F; bus.uio_in and bus.ena are ignored
module tt_um_onehot_pulse_decoder #(
  parameter int SYNC_STAGES = 2,
  parameter int PULSE_UNIT = 4
) (
  input logic clk,
  input logic rst_n,
  tt_um_onehot_pulse_decoder_if.slave bus
);
  localparam int CW = $clog2(4 * PULSE_UNIT);
  typedef enum logic [1:0] {IDLE, HOLD, PULSE} state_t;
  state_t state_q, state_d;
  logic [SYNC_STAGES-1:0][7:0] sync_q, sync_d;
  logic [SYNC_STAGES-1:0] fill_q, fill_d;
  logic load_dly_q, load_dly_d, armed_q, armed_d;
  logic [7:0] out_q, out_d;
  logic [2:0] code_q, code_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_load;
  logic done_q, done_d, ovr_q, ovr_d;
  logic [7:0] s;
  logic load_edge, unused;
  assign s = sync_q[SYNC_STAGES-1];
  assign sync_d = {sync_q[SYNC_STAGES-2:0], bus.ui_in};
  assign fill_d = {fill_q[SYNC_STAGES-2:0], 1'b1};
  assign load_dly_d = s[4];
  // A rise only counts once a genuine low has emerged from the refilled
  // synchroniser, so a load held high across reset release is not an edge.
  assign armed_d = armed_q | (fill_q[SYNC_STAGES-1] & ~s[4]);
  assign load_edge = armed_q & s[4] & ~load_dly_q;
  assign cnt_load = CW'((int'(s[7:6]) + 1) * PULSE_UNIT - 1);
  always_comb begin
    state_d = state_q;
    out_d = out_q;
    code_d = code_q;
    cnt_d = cnt_q;
    done_d = 1'b0;
    ovr_d = ovr_q;
    if (state_q == PULSE) begin
      ovr_d = ovr_q | load_edge;
      cnt_d = (cnt_q != '0) ? cnt_q - CW'(1) : cnt_q;
      if (cnt_q == '0) begin
        out_d = '0;
        state_d = IDLE;
        done_d = 1'b1;
      end
    end else if (load_edge && !s[3]) begin
      out_d = '0;
      ovr_d = 1'b0;
      state_d = IDLE;
    end else if (load_edge) begin
      out_d = 8'b1 << s[2:0];
      code_d = s[2:0];
      cnt_d = s[5] ? cnt_load : cnt_q;
      state_d = s[5] ? PULSE : HOLD;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      fill_q <= '0;
      load_dly_q <= 1'b0;
      armed_q <= 1'b0;
      state_q <= IDLE;
      out_q <= '0;
      code_q <= '0;
      cnt_q <= '0;
      done_q <= 1'b0;
      ovr_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      fill_q <= fill_d;
      load_dly_q <= load_dly_d;
      armed_q <= armed_d;
      state_q <= state_d;
      out_q <= out_d;
      code_q <= code_d;
      cnt_q <= cnt_d;
      done_q <= done_d;
      ovr_q <= ovr_d;
    end
  end
  assign bus.uo_out = out_q;
  assign bus.uio_out = {2'b00, ovr_q, done_q, state_q == PULSE, code_q};
  assign bus.uio_oe = 8'h3F;
  assign unused = &{1'b0, bus.uio_in, bus.ena};
endmodule

// File: tb/tb_tt_um_onehot_pulse_decoder.sv
// tb_tt_um_onehot_pulse_decoder: directed stimulus checked against a cycle model of the decoder rules
module tb_tt_um_onehot_pulse_decoder;
  localparam int S = 2, PU = 4;
  logic clk = 1'b0, rst_n = 1'b0;
  int checks = 0, errors = 0;
  tt_um_onehot_pulse_decoder_if bus();
  tt_um_onehot_pulse_decoder #(.SYNC_STAGES(S), .PULSE_UNIT(PU)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  logic [8:0] hist [0:S+1];
  logic [8:0] cmd, prev;
  logic rise;
  logic [7:0] m_out;
  logic [2:0] m_code;
  logic m_ovr, m_done, m_pulse;
  int m_rem;
  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic logic [7:0] mk(input logic [2:0] code, input logic valid, input logic load,
                                    input logic mode, input logic [1:0] len);
    return {len, mode, load, valid, code};
  endfunction
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic fire(input logic [7:0] v);
    bus.ui_in = v;
    cyc(4);
    bus.ui_in = v | 8'h10;
    cyc(3);
  endtask
  // Model: each input sample enters a delay line tagged as observed since reset;
  // a command acts SYNC_STAGES+1 edges after the load rise that carried it.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i <= S + 1; i++) hist[i] = '0;
      m_out = '0;
      m_code = '0;
      m_ovr = 1'b0;
      m_done = 1'b0;
      m_pulse = 1'b0;
      m_rem = 0;
    end else begin
      for (int i = S + 1; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = {1'b1, bus.ui_in};
      cmd = hist[S];
      prev = hist[S+1];
      rise = prev[8] && !prev[4] && cmd[4];
      m_done = 1'b0;
      if (m_pulse) begin
        m_ovr = m_ovr | rise;
        m_rem--;
        if (m_rem == 0) begin
          m_out = '0;
          m_pulse = 1'b0;
          m_done = 1'b1;
        end
      end else if (rise && !cmd[3]) begin
        m_out = '0;
        m_ovr = 1'b0;
      end else if (rise) begin
        m_out = 8'h01 << cmd[2:0];
        m_code = cmd[2:0];
        m_pulse = cmd[5];
        m_rem = (int'(cmd[7:6]) + 1) * PU;
      end
    end
  end
  always @(negedge clk) if (rst_n) begin
    chk("uo_out", bus.uo_out, m_out);
    chk("uio_out", bus.uio_out, {2'b00, m_ovr, m_done, m_pulse, m_code});
    chk("uio_oe", bus.uio_oe, 8'h3F);
    chk("onehot", 8'($countones(bus.uo_out) <= 1), 8'd1);
  end
  initial begin
    bus.ui_in = '0;
    bus.uio_in = '0;
    bus.ena = 1'b1;
    cyc(3);
    rst_n = 1'b1;
    cyc(10);
    chk("reset_uo", bus.uo_out, 8'h00);
    chk("reset_uio", bus.uio_out, 8'h00);
    chk("reset_oe", bus.uio_oe, 8'h3F);
    bus.ui_in = mk(5, 1, 0, 0, 0);
    cyc(4);
    bus.ui_in = mk(5, 1, 1, 0, 0);
    cyc(2);
    chk("hold5_edge2", bus.uo_out, 8'h00);
    cyc(1);
    chk("hold5_edge3", bus.uo_out, 8'h20);
    chk("hold5_uio", bus.uio_out, 8'h05);
    cyc(50);
    chk("hold5_held", bus.uo_out, 8'h20);
    fire(mk(7, 1, 0, 1, 2));
    chk("pulse7_start", bus.uo_out, 8'h80);
    chk("pulse7_busy", bus.uio_out, 8'h0F);
    bus.ui_in = mk(7, 1, 0, 1, 2);
    cyc(11);
    chk("pulse7_last", bus.uo_out, 8'h80);
    cyc(1);
    chk("pulse7_end", bus.uo_out, 8'h00);
    chk("pulse7_done", bus.uio_out, 8'h17);
    cyc(1);
    chk("pulse7_idle", bus.uio_out, 8'h07);
    fire(mk(7, 1, 0, 1, 2));
    chk("ovr_start", bus.uo_out, 8'h80);
    bus.ui_in = mk(1, 1, 0, 1, 2);
    cyc(2);
    bus.ui_in = mk(1, 1, 1, 1, 2);
    cyc(2);
    bus.ui_in = mk(1, 1, 0, 1, 2);
    cyc(7);
    chk("ovr_last", bus.uo_out, 8'h80);
    chk("ovr_flag", bus.uio_out, 8'h2F);
    cyc(1);
    chk("ovr_end", bus.uo_out, 8'h00);
    chk("ovr_done", bus.uio_out, 8'h37);
    cyc(5);
    chk("ovr_sticky", bus.uio_out, 8'h27);
    fire(mk(0, 0, 0, 0, 0));
    chk("clear_uo", bus.uo_out, 8'h00);
    chk("clear_uio", bus.uio_out, 8'h07);
    fire(mk(3, 1, 0, 0, 0));
    chk("hold3", bus.uo_out, 8'h08);
    fire(mk(6, 1, 0, 0, 0));
    chk("hold6", bus.uo_out, 8'h40);
    chk("hold6_uio", bus.uio_out, 8'h06);
    for (int c = 0; c < 8; c++) begin
      logic [7:0] e;
      e = 8'h01 << c;
      fire(mk(3'(c), 1, 0, 0, 0));
      chk("sweep", bus.uo_out, e);
    end
    fire(mk(2, 1, 0, 1, 3));
    chk("rst_pulse", bus.uo_out, 8'h04);
    cyc(5);
    #2 rst_n = 1'b0;
    #1 chk("rst_async_uo", bus.uo_out, 8'h00);
    chk("rst_async_uio", bus.uio_out, 8'h00);
    cyc(3);
    rst_n = 1'b1;
    cyc(10);
    chk("rst_held_uo", bus.uo_out, 8'h00);
    chk("rst_held_uio", bus.uio_out, 8'h00);
    fire(mk(2, 1, 0, 1, 3));
    chk("rearm_uo", bus.uo_out, 8'h04);
    chk("rearm_uio", bus.uio_out, 8'h0A);
    cyc(20);
    chk("rearm_end_uo", bus.uo_out, 8'h00);
    chk("rearm_end_uio", bus.uio_out, 8'h02);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
